// File: rtl/alu_sequencer.sv
// alu_sequencer: single-outstanding command sequencer wrapped around a
// registered ALU with one cycle of latency.
//
// A host command (operands + opcode) is registered into the ALU operand
// outputs. The sequencer waits one cycle for the ALU and then captures its
// result and flags. It presents them as a response until the host accepts.
// Saturating counters track how many captured responses had the err and
// overflow flags set.
//
// Ports
//   i_clk, i_rstn             clock, synchronous active-low reset
//   i_cmd_valid, o_cmd_ready  command handshake (ready only in IDLE)
//   i_cmd_arg0/1, i_cmd_oper  command operands and opcode
//   o_alu_arg0/1, o_alu_oper  registered operands and opcode to the ALU
//   i_alu_result, i_alu_flag  registered ALU result and flags {ovf,pos,neg,err}
//   o_rsp_valid, i_rsp_ready  response handshake
//   o_rsp_result, o_rsp_flag  captured ALU result and flags
//   o_err_cnt, o_ovf_cnt      saturating err / overflow counts
//   o_busy                    FSM is not in IDLE
module alu_sequencer #(
   parameter  int unsigned WIDTH  = 4,
   parameter  int unsigned CNT_W  = 8,
   localparam int unsigned OPER_W = 2,
   localparam int unsigned FLAG_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [WIDTH-1:0]  i_cmd_arg0,
   input  logic [WIDTH-1:0]  i_cmd_arg1,
   input  logic [OPER_W-1:0] i_cmd_oper,
   output logic [WIDTH-1:0]  o_alu_arg0,
   output logic [WIDTH-1:0]  o_alu_arg1,
   output logic [OPER_W-1:0] o_alu_oper,
   input  logic [WIDTH-1:0]  i_alu_result,
   input  logic [FLAG_W-1:0] i_alu_flag,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [WIDTH-1:0]  o_rsp_result,
   output logic [FLAG_W-1:0] o_rsp_flag,
   output logic [CNT_W-1:0]  o_err_cnt,
   output logic [CNT_W-1:0]  o_ovf_cnt,
   output logic              o_busy
);

   localparam int unsigned FLAG_ERR = 0;
   localparam int unsigned FLAG_OVF = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SAMPLE,
      ST_RESP
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   load_cmd;
   logic   capture;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath strobes
   always_comb begin
      state_d  = state_q;
      load_cmd = 1'b0;
      capture  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_cmd_valid) begin
               load_cmd = 1'b1;
               state_d  = ST_EXEC;
            end
         end
         // ALU registers its result at the end of this cycle
         ST_EXEC: begin
            state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            capture = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status outputs decoded straight from the state register
   assign o_cmd_ready = (state_q == ST_IDLE);
   assign o_rsp_valid = (state_q == ST_RESP);
   assign o_busy      = (state_q != ST_IDLE);

   // ALU operand registers: change only on command acceptance
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_alu_arg0 <= '0;
         o_alu_arg1 <= '0;
         o_alu_oper <= '0;
      end else if (load_cmd) begin
         o_alu_arg0 <= i_cmd_arg0;
         o_alu_arg1 <= i_cmd_arg1;
         o_alu_oper <= i_cmd_oper;
      end
   end

   // Response capture: held through RESP and after the handshake
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_rsp_result <= '0;
         o_rsp_flag   <= '0;
      end else if (capture) begin
         o_rsp_result <= i_alu_result;
         o_rsp_flag   <= i_alu_flag;
      end
   end

   // Saturating flag counters, both may step on the same capture edge
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_err_cnt <= '0;
         o_ovf_cnt <= '0;
      end else if (capture) begin
         if (i_alu_flag[FLAG_ERR] && (o_err_cnt != {CNT_W{1'b1}})) begin
            o_err_cnt <= o_err_cnt + CNT_W'(1);
         end
         if (i_alu_flag[FLAG_OVF] && (o_ovf_cnt != {CNT_W{1'b1}})) begin
            o_ovf_cnt <= o_ovf_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// A behavioural ALU (one-cycle registered) feeds the main DUT. A second
// instance with 2-bit counters sees a constant err+ovf flag so that counter
// saturation can be observed.
module tb_alu_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned SAT_W = 2;

   logic             clk = 1'b0;
   logic             rstn;
   logic             cmd_valid;
   logic [WIDTH-1:0] arg0, arg1;
   logic [1:0]       oper;
   logic             rsp_ready;

   logic             cmd_ready, rsp_valid, busy;
   logic [WIDTH-1:0] alu_arg0, alu_arg1, rsp_result;
   logic [1:0]       alu_oper;
   logic [3:0]       rsp_flag;
   logic [CNT_W-1:0] err_cnt, ovf_cnt;

   logic             s_cmd_ready, s_rsp_valid, s_busy;
   logic [WIDTH-1:0] s_alu_arg0, s_alu_arg1, s_rsp_result;
   logic [1:0]       s_alu_oper;
   logic [3:0]       s_rsp_flag;
   logic [SAT_W-1:0] s_err_cnt, s_ovf_cnt;

   logic [WIDTH-1:0] alu_res;
   logic [3:0]       alu_flag;
   logic [3:0]       sat_flag;

   int n_vec = 0;
   int n_bad = 0;
   int exp_err = 0;
   int exp_ovf = 0;
   int rsp_seen = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_arg0(arg0), .i_cmd_arg1(arg1), .i_cmd_oper(oper),
      .o_alu_arg0(alu_arg0), .o_alu_arg1(alu_arg1), .o_alu_oper(alu_oper),
      .i_alu_result(alu_res), .i_alu_flag(alu_flag),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_result(rsp_result), .o_rsp_flag(rsp_flag),
      .o_err_cnt(err_cnt), .o_ovf_cnt(ovf_cnt), .o_busy(busy)
   );

   alu_sequencer #(.WIDTH(WIDTH), .CNT_W(SAT_W)) dut_sat (
      .i_clk(clk), .i_rstn(rstn),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(s_cmd_ready),
      .i_cmd_arg0(arg0), .i_cmd_arg1(arg1), .i_cmd_oper(oper),
      .o_alu_arg0(s_alu_arg0), .o_alu_arg1(s_alu_arg1), .o_alu_oper(s_alu_oper),
      .i_alu_result(alu_res), .i_alu_flag(sat_flag),
      .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_result(s_rsp_result), .o_rsp_flag(s_rsp_flag),
      .o_err_cnt(s_err_cnt), .o_ovf_cnt(s_ovf_cnt), .o_busy(s_busy)
   );

   // Behavioural ALU: returns {flag, result}, flag = {ovf, pos, neg, err}
   function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
      logic [3:0] r;
      logic       err, ovf, stop;
      int         n;
      err = 1'b0;
      ovf = 1'b0;
      case (op)
         2'd0: begin
            r   = a - b;
            ovf = (a[3] != b[3]) && (r[3] != a[3]);
         end
         2'd1: r = ~(a & b);
         2'd2: begin
            n    = 0;
            stop = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (!stop && a[i]) n++;
               else stop = 1'b1;
            end
            r = 4'(n);
         end
         default: begin
            r   = 4'b0001 << a[1:0];
            err = (a[3:2] != 2'b00);
         end
      endcase
      return {ovf, (!r[3] && (r != 4'd0)), r[3], err, r};
   endfunction

   always @(posedge clk) {alu_flag, alu_res} <= alu_f(alu_arg0, alu_arg1, alu_oper);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat_of(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_rsp(input logic [3:0] flag);
      if (flag[0]) exp_err++;
      if (flag[3]) exp_ovf++;
      rsp_seen++;
   endtask

   task automatic check_counts();
      check("err_cnt", 32'(err_cnt), 32'(sat_of(exp_err, 255)));
      check("ovf_cnt", 32'(ovf_cnt), 32'(sat_of(exp_ovf, 255)));
      check("sat_err_cnt", 32'(s_err_cnt), 32'(sat_of(rsp_seen, 3)));
      check("sat_ovf_cnt", 32'(s_ovf_cnt), 32'(sat_of(rsp_seen, 3)));
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      rstn      = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rstn     = 1'b1;
      exp_err  = 0;
      exp_ovf  = 0;
      rsp_seen = 0;
   endtask

   // One command: accept, check latency, hold RESP for `hold` cycles, handshake
   task automatic run_cmd(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] op,
                          input int hold, input logic [7:0] exp, input string tag);
      int w;
      int lat;
      logic [3:0] res_q;
      @(negedge clk);
      cmd_valid = 1'b1;
      arg0      = a0;
      arg1      = a1;
      oper      = op;
      rsp_ready = 1'b0;
      w = 0;
      while (!cmd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         check({tag, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd3);
      model_rsp(exp[7:4]);
      check({tag, "_result"}, 32'(rsp_result), 32'(exp[3:0]));
      check({tag, "_flag"}, 32'(rsp_flag), 32'(exp[7:4]));
      check({tag, "_alu_arg0"}, 32'(alu_arg0), 32'(a0));
      check_counts();
      res_q = rsp_result;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1'b1;
         arg0      = 4'($urandom);
         arg1      = 4'($urandom);
         oper      = 2'($urandom);
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, "_hold_result"}, 32'(rsp_result), 32'(res_q));
         check({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
         check({tag, "_hold_alu_arg0"}, 32'(alu_arg0), 32'(a0));
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
      check({tag, "_after_result"}, 32'(rsp_result), 32'(exp[3:0]));
      check({tag, "_after_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   typedef struct {
      logic [3:0] a0;
      logic [3:0] a1;
      logic [1:0] op;
      logic [3:0] res;
      logic [3:0] flag;
   } vec_t;

   vec_t tbl[11];
   logic [7:0] q[$];
   int acc_cyc[3];

   initial begin
      int n_acc, n_rsp;
      logic [7:0] e;
      bit seen_valid;

      tbl[0]  = '{4'h3, 4'h1, 2'd0, 4'h2, 4'b0100};
      tbl[1]  = '{4'h7, 4'hF, 2'd0, 4'h8, 4'b1010};
      tbl[2]  = '{4'h8, 4'h1, 2'd0, 4'h7, 4'b1100};
      tbl[3]  = '{4'h5, 4'h5, 2'd0, 4'h0, 4'b0000};
      tbl[4]  = '{4'hC, 4'hA, 2'd1, 4'h7, 4'b0100};
      tbl[5]  = '{4'hF, 4'hF, 2'd1, 4'h0, 4'b0000};
      tbl[6]  = '{4'h7, 4'h0, 2'd2, 4'h3, 4'b0100};
      tbl[7]  = '{4'hF, 4'h0, 2'd2, 4'h4, 4'b0100};
      tbl[8]  = '{4'h2, 4'h0, 2'd3, 4'h4, 4'b0100};
      tbl[9]  = '{4'h3, 4'h0, 2'd3, 4'h8, 4'b0010};
      tbl[10] = '{4'h6, 4'h0, 2'd3, 4'h4, 4'b0101};

      sat_flag  = 4'b1001;
      rstn      = 1'b0;
      cmd_valid = 1'b1;
      arg0      = 4'h3;
      arg1      = 4'h1;
      oper      = 2'd0;
      rsp_ready = 1'b0;

      // Reset values, and no acceptance while reset is held
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu", 32'({alu_arg0, alu_arg1, alu_oper}), 32'd0);
      check("rst_rsp", 32'({rsp_result, rsp_flag}), 32'd0);
      check("rst_cnt", 32'({err_cnt, ovf_cnt}), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("first_accept_busy", 32'(busy), 32'd1);
      check("first_accept_arg0", 32'(alu_arg0), 32'h3);
      rst_pulse();

      // Table vectors, including the single-op case 3-1
      foreach (tbl[i]) run_cmd(tbl[i].a0, tbl[i].a1, tbl[i].op, 0,
                               {tbl[i].flag, tbl[i].res}, $sformatf("tbl%0d", i));

      // Backpressure: response held five cycles, new commands ignored
      run_cmd(4'h3, 4'h1, 2'd0, 5, {4'b0100, 4'h2}, "bp");

      // Back-to-back with valid and ready tied high
      @(negedge clk);
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      arg0 = 4'h9; arg1 = 4'h4; oper = 2'd0;
      n_acc = 0;
      n_rsp = 0;
      for (int c = 0; c < 40 && n_rsp < 3; c++) begin
         if (c > 0) @(negedge clk);
         if (rsp_valid) begin
            e = (q.size() > 0) ? q.pop_front() : 8'hxx;
            check($sformatf("b2b_result%0d", n_rsp), 32'(rsp_result), 32'(e[3:0]));
            check($sformatf("b2b_flag%0d", n_rsp), 32'(rsp_flag), 32'(e[7:4]));
            model_rsp(e[7:4]);
            n_rsp++;
         end
         if (cmd_ready && cmd_valid) begin
            acc_cyc[n_acc] = c;
            q.push_back(alu_f(arg0, arg1, oper));
            n_acc++;
         end else if (n_acc < 3) begin
            arg0 = 4'(4'h9 + 4'(n_acc));
            arg1 = 4'(n_acc);
            oper = 2'(n_acc);
         end else begin
            cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      check("b2b_rsp_count", 32'(n_rsp), 32'd3);
      check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
      @(negedge clk);
      check_counts();

      // Saturation of the 2-bit counters over five responses
      rst_pulse();
      for (int i = 0; i < 5; i++) begin
         run_cmd(4'(i), 4'h2, 2'd0, 0, alu_f(4'(i), 4'h2, 2'd0), $sformatf("sat%0d", i));
      end
      check("sat_final_err", 32'(s_err_cnt), 32'd3);
      check("sat_final_ovf", 32'(s_ovf_cnt), 32'd3);

      // Randomized commands against the behavioural ALU
      for (int i = 0; i < 120; i++) begin
         logic [3:0] ra0, ra1;
         logic [1:0] rop;
         ra0 = 4'($urandom);
         ra1 = 4'($urandom);
         rop = 2'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_cmd(ra0, ra1, rop, int'($urandom_range(0, 2)), alu_f(ra0, ra1, rop),
                 $sformatf("rnd%0d", i));
      end

      // Reset during SAMPLE aborts the command in flight
      @(negedge clk);
      cmd_valid = 1'b1;
      arg0 = 4'h6; arg1 = 4'h0; oper = 2'd3;
      check("abort_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_busy_sample", 32'(busy), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_err  = 0;
      exp_ovf  = 0;
      rsp_seen = 0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
      check("abort_alu", 32'({alu_arg0, alu_arg1, alu_oper}), 32'd0);
      check("abort_rsp", 32'({rsp_result, rsp_flag}), 32'd0);
      check_counts();
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) seen_valid = 1'b1;
      end
      check("abort_no_rsp", 32'(seen_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
